// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter and receiver paths.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_CLEANUP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  // Clocks from start-bit detection to the middle of the start bit.
  function automatic int half_bit_count(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receive path: two-flop synchroniser on the serial input followed by a
// mid-bit sampling 8N1 deserialiser with glitch and framing-error rejection.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_serial_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(half_bit_count(CLKS_PER_BIT));
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic [1:0]       sync_q;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             done_q, done_d;
  logic             rx_line;

  assign rx_line = sync_q[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= {2{IDLE_LEVEL}};
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_serial_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (rx_line == 1'b0) state_d = RX_START;
      end
      RX_START: begin
        // A start bit must still be low at its centre, otherwise it was noise.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = (rx_line == 1'b0) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_line;
          idx_d          = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_line == IDLE_LEVEL) begin
            byte_d  = shift_q;
            done_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_line == IDLE_LEVEL) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_byte_o = byte_q;
  assign rx_done_o = done_q;

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: inline transmit FSM with registered line outputs and
// an independent receive core.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_TX_Start,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done,
  input  logic       i_RX_Serial,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Done
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       data_q, data_d;
  logic             serial_q, serial_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= TX_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      serial_q <= IDLE_LEVEL;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Line outputs are registered from the current state, so they lag the
  // state register by one clock.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    data_d   = data_q;
    serial_d = IDLE_LEVEL;
    active_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (i_TX_Start) begin
          data_d  = i_TX_Byte;
          state_d = TX_START;
        end
      end
      TX_START: begin
        serial_d = 1'b0;
        active_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        serial_d = data_q[idx_q];
        active_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = TX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        active_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = TX_CLEANUP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_CLEANUP: begin
        // The line is already idle here; accepting a request now leaves
        // exactly one idle-high clock between back-to-back frames.
        done_d = 1'b1;
        cnt_d  = '0;
        idx_d  = '0;
        if (i_TX_Start) begin
          data_d  = i_TX_Byte;
          state_d = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign o_TX_Serial = serial_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_core (
    .clk_i      (i_clock),
    .rst_i      (i_reset),
    .rx_serial_i(i_RX_Serial),
    .rx_byte_o  (o_RX_Byte),
    .rx_done_o  (o_RX_Done)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver: scoreboard queues for TX and RX bytes,
// per-cycle TX line checking and monitor-driven RX byte checking.
`timescale 1ns/1ps
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CPB    = 87;
  localparam int CLK_NS = 100;
  localparam int BIT_NS = CPB * CLK_NS;

  logic       i_clock     = 1'b0;
  logic       i_reset     = 1'b1;
  logic       i_TX_Start  = 1'b0;
  logic [7:0] i_TX_Byte   = 8'h00;
  logic       i_RX_Serial = 1'b1;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Done;

  always #(CLK_NS / 2) i_clock = ~i_clock;

  uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_TX_Start (i_TX_Start),
    .i_TX_Byte  (i_TX_Byte),
    .o_TX_Active(o_TX_Active),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Done  (o_TX_Done),
    .i_RX_Serial(i_RX_Serial),
    .o_RX_Byte  (o_RX_Byte),
    .o_RX_Done  (o_RX_Done)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // TX monitor: every active cycle is compared with the expected frame bit.
  logic       tx_active_prev = 1'b0;
  logic       tx_in_frame    = 1'b0;
  int         tx_cyc         = 0;
  int         tx_idle_cnt    = 0;
  int         tx_last_gap    = -1;
  int         tx_starts      = 0;
  logic [9:0] tx_frame       = '1;

  always @(negedge i_clock) begin : tx_mon
    logic [7:0] e;
    if (i_reset) begin
      tx_in_frame    = 1'b0;
      tx_active_prev = 1'b0;
      tx_idle_cnt    = 0;
    end else begin
      if (o_TX_Active && !tx_active_prev) begin
        tx_starts++;
        tx_last_gap = tx_idle_cnt;
        tx_idle_cnt = 0;
        tx_cyc      = 0;
        if (tx_q.size() == 0) begin
          check("tx_spurious_frame", 32'(o_TX_Active), 32'd0);
        end else begin
          e           = tx_q.pop_front();
          tx_frame    = {1'b1, e, 1'b0};
          tx_in_frame = 1'b1;
          $display("TX transaction: frame started for byte %02h", e);
        end
      end
      if (o_TX_Active && tx_in_frame) begin
        check("tx_serial", 32'(o_TX_Serial), 32'(tx_frame[tx_cyc / CPB]));
        tx_cyc++;
      end
      if (!o_TX_Active && tx_active_prev && tx_in_frame) begin
        check("tx_active_len", 32'(tx_cyc), 32'(10 * CPB));
        check("tx_done_at_end", 32'(o_TX_Done), 32'd1);
        tx_in_frame = 1'b0;
      end else begin
        check("tx_done_quiet", 32'(o_TX_Done), 32'd0);
      end
      if (!o_TX_Active) begin
        tx_idle_cnt++;
        check("tx_idle_line", 32'(o_TX_Serial), 32'd1);
      end
      tx_active_prev = o_TX_Active;
    end
  end

  always @(negedge i_clock) begin : rx_mon
    logic [7:0] e;
    if (!i_reset && o_RX_Done === 1'b1) begin
      if (rx_q.size() == 0) begin
        check("rx_spurious_done", 32'(o_RX_Done), 32'd0);
      end else begin
        e = rx_q.pop_front();
        $display("RX transaction: byte %02h expected %02h", o_RX_Byte, e);
        check("rx_byte", 32'(o_RX_Byte), 32'(e));
      end
    end
  end

  task automatic send_rx(input logic [7:0] b, input logic stop_bit, input int extra_ns,
                         input bit push);
    if (push) rx_q.push_back(b);
    i_RX_Serial = 1'b0;
    #(BIT_NS + extra_ns);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = b[i];
      #(BIT_NS);
    end
    i_RX_Serial = stop_bit;
    #(BIT_NS);
    i_RX_Serial = 1'b1;
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while ((rx_q.size() != 0 || tx_q.size() != 0 || o_TX_Active) && n < budget) begin
      @(negedge i_clock);
      n++;
    end
    repeat (5) @(negedge i_clock);
    check({tag, "_rx_drained"}, 32'(rx_q.size()), 32'd0);
    check({tag, "_tx_drained"}, 32'(tx_q.size()), 32'd0);
  endtask

  task automatic tx_pulse(input logic [7:0] b);
    tx_q.push_back(b);
    i_TX_Byte  = b;
    i_TX_Start = 1'b1;
    @(negedge i_clock);
    i_TX_Start = 1'b0;
  endtask

  initial begin
    #(20_000_000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    repeat (3) @(negedge i_clock);
    check("rst_tx_serial", 32'(o_TX_Serial), 32'd1);
    check("rst_tx_active", 32'(o_TX_Active), 32'd0);
    check("rst_tx_done",   32'(o_TX_Done),   32'd0);
    check("rst_rx_byte",   32'(o_RX_Byte),   32'h00);
    check("rst_rx_done",   32'(o_RX_Done),   32'd0);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clock);

    // Single TX frame.
    tx_pulse(8'hCD);
    drain(2000, "tx_cd");

    // RX frame with the start bit stretched by 10 clocks.
    send_rx(8'h3F, 1'b1, 1000, 1'b1);
    drain(2000, "rx_skew");
    check("rx_skew_hold", 32'(o_RX_Byte), 32'h3F);

    // 20-clock low glitch must not start a frame.
    i_RX_Serial = 1'b0;
    repeat (20) @(negedge i_clock);
    i_RX_Serial = 1'b1;
    repeat (200) @(negedge i_clock);
    check("glitch_byte_kept", 32'(o_RX_Byte), 32'h3F);
    check("glitch_rx_idle", 32'(dut.u_rx_core.state_q), 32'(RX_IDLE));

    // Back-to-back RX frames alongside back-to-back TX frames.
    fork
      begin
        send_rx(8'hA5, 1'b1, 0, 1'b1);
        send_rx(8'h5A, 1'b1, 0, 1'b1);
      end
      begin
        tx_q.push_back(8'h3C);
        tx_q.push_back(8'hC3);
        base       = tx_starts;
        i_TX_Byte  = 8'h3C;
        i_TX_Start = 1'b1;
        @(negedge i_clock);
        i_TX_Byte = 8'hC3;
        n = 0;
        while (tx_starts < base + 2 && n < 3000) begin
          @(negedge i_clock);
          n++;
        end
        i_TX_Start = 1'b0;
        check("tx_b2b_frames", 32'(tx_starts - base), 32'd2);
        check("tx_b2b_gap", 32'(tx_last_gap), 32'd1);
      end
    join
    drain(3000, "b2b");

    // Framing error followed by a valid frame.
    send_rx(8'h55, 1'b0, 0, 1'b0);
    #(2 * BIT_NS);
    check("framing_byte_kept", 32'(o_RX_Byte), 32'h5A);
    send_rx(8'h81, 1'b1, 0, 1'b1);
    drain(2000, "framing");
    check("framing_recover", 32'(o_RX_Byte), 32'h81);

    // Reset during data bit 3 of both a TX and an RX frame.
    tx_pulse(8'hF0);
    fork
      send_rx(8'h96, 1'b1, 0, 1'b0);
      begin
        repeat (4 * CPB + 40) @(negedge i_clock);
        #20;
        i_reset = 1'b1;
        #1;
        check("midrst_tx_serial", 32'(o_TX_Serial), 32'd1);
        check("midrst_tx_active", 32'(o_TX_Active), 32'd0);
        check("midrst_tx_done",   32'(o_TX_Done),   32'd0);
        check("midrst_rx_done",   32'(o_RX_Done),   32'd0);
        check("midrst_rx_byte",   32'(o_RX_Byte),   32'h00);
      end
    join
    repeat (10) @(negedge i_clock);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clock);
    tx_pulse(8'h00);
    send_rx(8'hFF, 1'b1, 0, 1'b1);
    drain(2000, "post_rst");
    check("post_rst_rx_byte", 32'(o_RX_Byte), 32'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
